// File: rtl/led_pattern_ctrl.sv
// Command-driven LED pattern sequencer: accepts mode/repeat commands and steps SWEEP/FILL/BLINK/ALT
// patterns at mclk/2^DIV_W. Define LED_ACT_LOW_EN for active-low LED boards (all led values inverted).
module led_pattern_ctrl #(
    parameter int DIV_W = 25
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_reps,
    input  logic       stop,
    output logic       busy,
    output logic       done,
    output logic [7:0] led
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    localparam logic [1:0] M_SWEEP = 2'd0;
    localparam logic [1:0] M_FILL  = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;

    logic             state;
    logic [DIV_W-1:0] presc;
    logic [3:0]       step;
    logic [3:0]       pass;
    logic [1:0]       mode;
    logic [3:0]       reps;
    logic             tick;

    // Active-high pattern value for a given mode and step.
    function automatic logic [7:0] pattern(input logic [1:0] m, input logic [3:0] i);
        logic [7:0] p;
        case (m)
            M_SWEEP: p = i[3] ? (8'h80 >> i[2:0]) : (8'h01 << i[2:0]);
            M_FILL:  p = 8'hFF >> (3'd7 - i[2:0]);
            M_BLINK: p = i[0] ? 8'h00 : 8'hFF;
            default: p = i[0] ? 8'hAA : 8'h55;
        endcase
        return p;
    endfunction

    function automatic logic [3:0] last_step(input logic [1:0] m);
        logic [3:0] l;
        case (m)
            M_SWEEP: l = 4'd15;
            M_FILL:  l = 4'd7;
            default: l = 4'd1;
        endcase
        return l;
    endfunction

    // Board polarity applied at the output register only.
    function automatic logic [7:0] drive(input logic [7:0] v);
`ifdef LED_ACT_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign tick      = (state == S_RUN) && (presc == '1);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            presc <= '0;
            step  <= 4'd0;
            pass  <= 4'd0;
            mode  <= 2'd0;
            reps  <= 4'd0;
            done  <= 1'b0;
            led   <= drive(8'h00);
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (cmd_valid) begin
                    mode  <= cmd_mode;
                    reps  <= cmd_reps;
                    step  <= 4'd0;
                    pass  <= 4'd0;
                    presc <= '0;
                    state <= S_RUN;
                    led   <= drive(pattern(cmd_mode, 4'd0));
                end
            end else if (stop) begin
                // Abort wins over any same-cycle tick or completion.
                state <= S_IDLE;
                led   <= drive(8'h00);
            end else begin
                presc <= presc + 1'b1;
                if (tick) begin
                    if (step == last_step(mode)) begin
                        if ((reps != 4'd0) && (pass == reps - 4'd1)) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                            led   <= drive(8'h00);
                        end else begin
                            step <= 4'd0;
                            pass <= pass + 4'd1;
                            led  <= drive(pattern(mode, 4'd0));
                        end
                    end else begin
                        step <= step + 4'd1;
                        led  <= drive(pattern(mode, step + 4'd1));
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl at DIV_W=3 (8 cycles per step); honours LED_ACT_LOW_EN.
module tb_led_pattern_ctrl;

    localparam int DIV_W = 3;
    localparam int SPS   = 1 << DIV_W;

`ifdef LED_ACT_LOW_EN
    localparam logic [7:0] POL = 8'hFF;
`else
    localparam logic [7:0] POL = 8'h00;
`endif

    logic       mclk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_reps;
    logic       stop;
    logic       busy;
    logic       done;
    logic [7:0] led;

    int checks = 0;
    int errors = 0;

    led_pattern_ctrl #(.DIV_W(DIV_W)) dut (
        .mclk(mclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_reps(cmd_reps), .stop(stop),
        .busy(busy), .done(done), .led(led)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Reference: pass length and LED value straight from the pattern definitions.
    function automatic int plen(input int m);
        case (m)
            0: return 16;
            1: return 8;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] exp_pat(input int m, input int i);
        int v;
        case (m)
            0: v = (i < 8) ? (1 << i) : (1 << (15 - i));
            1: v = (2 << i) - 1;
            2: v = (i == 0) ? 255 : 0;
            default: v = (i == 0) ? 85 : 170;
        endcase
        return 8'(v) ^ POL;
    endfunction

    // Expected led t cycles after the accept edge, while still running.
    function automatic logic [7:0] exp_led(input int m, input int t);
        return exp_pat(m, (t / SPS) % plen(m));
    endfunction

    task automatic next_cycle();
        @(posedge mclk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (led !== POL || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_init: led=%h busy=%b done=%b ready=%b, want led=%h 0 0 1", led, busy, done, cmd_ready, POL);
        end
        cmd_mode = 2'd1; cmd_reps = 4'd0; cmd_valid = 1'b1;
        next_cycle();
        cmd_valid = 1'b0;
        repeat (20) next_cycle();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun: busy=%b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (led !== POL || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: led=%h busy=%b done=%b ready=%b, want led=%h 0 0 1", led, busy, done, cmd_ready, POL);
        end
        next_cycle();
        rst = 1'b0;
        repeat (10) next_cycle();
        checks++;
        if (led !== POL || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: led=%h busy=%b ready=%b, want led=%h 0 1", led, busy, cmd_ready, POL);
        end
    endtask

    task automatic test_sweep();
        int tend = plen(0) * SPS;
        int ndone = 0;
        cmd_mode = 2'd0; cmd_reps = 4'd1; cmd_valid = 1'b1;
        next_cycle();
        cmd_valid = 1'b0;
        for (int t = 0; t < tend; t++) begin
            checks++;
            if (led !== exp_led(0, t) || busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL sweep_t%0d: led=%h busy=%b ready=%b done=%b, want led=%h 1 0 0", t, led, busy, cmd_ready, done, exp_led(0, t));
            end
            next_cycle();
        end
        if (done === 1'b1) ndone++;
        checks++;
        if (done !== 1'b1 || led !== POL || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL sweep_end: done=%b led=%h busy=%b ready=%b, want 1 %h 0 1", done, led, busy, cmd_ready, POL);
        end
        for (int t = 0; t < 10; t++) begin
            next_cycle();
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL sweep_done_count: got %0d want 1", ndone);
        end
    endtask

    task automatic test_fill_two_pass();
        int tend = 2 * plen(1) * SPS;
        int ndone = 0;
        int tdone = -1;
        cmd_mode = 2'd1; cmd_reps = 4'd2; cmd_valid = 1'b1;
        next_cycle();
        cmd_valid = 1'b0;
        for (int t = 0; t < tend + 12; t++) begin
            if (done === 1'b1) begin
                ndone++;
                tdone = t;
            end
            if (t < tend) begin
                checks++;
                if (led !== exp_led(1, t) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_t%0d: led=%h busy=%b, want %h 1", t, led, busy, exp_led(1, t));
                end
            end else if (t == tend) begin
                checks++;
                if (led !== POL || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_end: led=%h busy=%b, want %h 0", led, busy, POL);
                end
            end
            next_cycle();
        end
        checks++;
        if (ndone != 1 || tdone != tend) begin
            errors++;
            $display("FAIL fill_done: count=%0d at t=%0d, want 1 at t=%0d", ndone, tdone, tend);
        end
    endtask

    task automatic test_continuous_stop();
        int ndone = 0;
        cmd_mode = 2'd3; cmd_reps = 4'd0; cmd_valid = 1'b1;
        next_cycle();
        cmd_valid = 1'b0;
        for (int t = 0; t < 16 * SPS; t++) begin
            if (done === 1'b1) ndone++;
            checks++;
            if (led !== exp_led(3, t) || busy !== 1'b1) begin
                errors++;
                $display("FAIL alt_t%0d: led=%h busy=%b, want %h 1", t, led, busy, exp_led(3, t));
            end
            // Raise stop so that it lands on the tick edge at t = 16*SPS.
            if (t == 16 * SPS - 1) stop = 1'b1;
            next_cycle();
        end
        stop = 1'b0;
        checks++;
        if (led !== POL || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL alt_stop: led=%h busy=%b done=%b, want %h 0 0", led, busy, done, POL);
        end
        next_cycle();
        if (done === 1'b1) ndone++;
        checks++;
        if (ndone != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL alt_no_done: done count=%0d busy=%b, want 0 0", ndone, busy);
        end
    endtask

    task automatic test_back_to_back();
        int tend = plen(2) * SPS;
        cmd_mode = 2'd2; cmd_reps = 4'd1; cmd_valid = 1'b1;
        next_cycle();
        for (int t = 0; t < tend; t++) begin
            if (t == 5) cmd_mode = 2'd3;
            checks++;
            if (cmd_ready !== 1'b0 || led !== exp_led(2, t)) begin
                errors++;
                $display("FAIL b2b_run_t%0d: ready=%b led=%h, want 0 %h", t, cmd_ready, led, exp_led(2, t));
            end
            next_cycle();
        end
        checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b1 || led !== POL) begin
            errors++;
            $display("FAIL b2b_done: done=%b ready=%b led=%h, want 1 1 %h", done, cmd_ready, led, POL);
        end
        next_cycle();
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || led !== exp_led(3, 0)) begin
            errors++;
            $display("FAIL b2b_second: busy=%b done=%b led=%h, want 1 0 %h", busy, done, led, exp_led(3, 0));
        end
        for (int t = 1; t <= tend; t++) begin
            next_cycle();
            if (t < tend) begin
                checks++;
                if (led !== exp_led(3, t)) begin
                    errors++;
                    $display("FAIL b2b_second_t%0d: led=%h want %h", t, led, exp_led(3, t));
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_end: done=%b busy=%b, want 1 0", done, busy);
        end
        next_cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int m = int'($urandom_range(0, 3));
            int r = int'($urandom_range(1, 2));
            int tend = r * plen(m) * SPS;
            int ts = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, tend - 1)) : tend + 100;
            int errs0 = errors;
            cmd_mode = 2'(m); cmd_reps = 4'(r); cmd_valid = 1'b1;
            next_cycle();
            cmd_valid = 1'b0;
            for (int t = 0; t <= tend + 2; t++) begin
                logic [7:0] el;
                logic       eb;
                logic       ed;
                if (t >= ts) begin
                    el = POL; eb = 1'b0; ed = 1'b0;
                end else if (t < tend) begin
                    el = exp_led(m, t); eb = 1'b1; ed = 1'b0;
                end else begin
                    el = POL; eb = 1'b0; ed = (t == tend);
                end
                checks++;
                if (led !== el || busy !== eb || done !== ed) begin
                    errors++;
                    if (errors - errs0 <= 3)
                        $display("FAIL rand%0d_m%0d_r%0d_t%0d: led=%h busy=%b done=%b, want %h %b %b",
                                 n, m, r, t, led, busy, done, el, eb, ed);
                end
                if (t == ts - 1) stop = 1'b1;
                next_cycle();
                stop = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_reps = 4'd0; stop = 1'b0;
        repeat (3) @(posedge mclk);
        #1 rst = 1'b0;
        next_cycle();
        test_reset();
        test_sweep();
        test_fill_two_pass();
        test_continuous_stop();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Command-driven sequencer for the 8-bit board LED bank. It accepts a pattern command (mode plus repeat count) over a valid/ready handshake. It then steps the chosen pattern at a divided tick rate derived from `mclk`, and drives the registered `led` outputs. It replaces free-running LED walkers so that top-level logic can start, stop and chain LED effects.

## Interface
Parameters:
- `DIV_W`, default 25. Prescaler width. One pattern step lasts 2^DIV_W `mclk` cycles.

Ports (one clock; reset is asynchronous and active-high):
- `mclk` input, 1 bit. System clock. Every register is clocked on its rising edge.
- `rst` input, 1 bit. Asynchronous, active-high reset.
- `cmd_valid` input, 1 bit. A command is presented.
- `cmd_ready` output, 1 bit. Equals 1 when the block is idle. Combinational from the state.
- `cmd_mode` input, 2 bits. Pattern select. Sampled on accept.
- `cmd_reps` input, 4 bits. Number of passes. 0 means continuous. Sampled on accept.
- `stop` input, 1 bit. Abort request. Sampled every cycle.
- `busy` output, 1 bit. Equals 1 in RUN.
- `done` output, 1 bit. One-cycle pulse when a finite command completes.
- `led` output, 8 bits. Registered LED drive.

## Operation
- States: IDLE and RUN. Reset puts the block in IDLE.
- Reset values: `led`=8'h00 (8'hFF when `LED_ACT_LOW_EN` is defined), `busy`=0, `done`=0, `cmd_ready`=1. The prescaler, step, pass, mode and reps registers all reset to 0.
- Accept: in IDLE, `cmd_valid`=1 is accepted (`cmd_ready` is 1). On that edge the block:
  - latches mode and reps,
  - clears the step, pass and prescaler counters,
  - enters RUN,
  - loads `led` with the step-0 pattern.
- While in RUN, `cmd_ready`=0 and `cmd_valid` is ignored.
- Tick: the DIV_W-bit prescaler increments every RUN cycle and wraps naturally. A tick occurs on any RUN edge where the prescaler equals all-ones.
- On each tick, the step counter advances and `led` loads the pattern for the new step.
- Pass length and `led` value at step i:
  - Mode 0 (SWEEP), 16 steps. i=0..7 gives 1<<i. i=8..15 gives 1<<(15-i). The sequence is therefore 01,02,..,80,80,40,..,01.
  - Mode 1 (FILL), 8 steps. `led` = (2<<i)-1, giving 01,03,07,..,FF.
  - Mode 2 (BLINK), 2 steps. FF, then 00.
  - Mode 3 (ALT), 2 steps. 55, then AA.
- When a tick occurs on the last step of a pass:
  - The step counter wraps to 0 and the pass counter increments (4 bits, wraps).
  - Finite case (reps≠0): if the pass counter equals reps-1 before the increment, the block instead returns to IDLE. On that edge `led` goes to 00 and `done` pulses 1 for exactly one cycle.
  - Continuous case (reps=0): the pattern repeats indefinitely. `done` never fires.
- Stop: `stop`=1 in RUN returns the block to IDLE on the next edge, with `led` at 00 and no `done` pulse.
  - `stop` has priority over a same-cycle tick and over completion.
  - `stop` in IDLE is ignored.
- Reset asserted mid-run forces the reset values immediately, independent of `mclk`.

## Timing
- Accept edge E0: `busy`=1 and `led` holds the step-0 value visible after E0.
- Step k starts at edge E0 + k·2^DIV_W.
- A finite command ends at edge E0 + reps·passlen·2^DIV_W. After that edge, `busy`=0, `done`=1 and `led`=00.
- On the following edge, `done`=0, `cmd_ready`=1 (already 1 combinationally after the end edge), and a new command may be accepted.
- Back-to-back commands: a command held valid during the `done` cycle is accepted on that edge. This gives one idle-LED cycle between commands.
- `stop` seen at edge Es: IDLE with `led`=00 after Es.

## Configuration
- `LED_ACT_LOW_EN`:
  - Defined: `led` is the bitwise inverse of every value above, and both the reset and IDLE value become 8'hFF. This suits boards with active-low LEDs.
  - Undefined: `led` is active-high as described above.
  - No other behaviour changes.

## Test plan
Use DIV_W=3 (8 cycles per step) for all scenarios.
- Reset: assert `rst` asynchronously mid-RUN. Expect `led`=00, `busy`=0, `done`=0 and `cmd_ready`=1 without waiting for a clock edge. After release, IDLE holds.
- SWEEP: mode 0, reps 1. Expect `led` to follow 01,02,04,..,80,80,40,..,01, each value held 8 cycles. `done` pulses once, 128 cycles after accept, with `led`=00.
- FILL, two passes: mode 1, reps 2. Expect 01,03,..,FF twice, then `done` at 128 cycles. Check that exactly one `done` pulse occurs.
- Continuous with stop: mode 3, reps 0. Expect 55/AA alternating for 100+ cycles with no `done`. Assert `stop` on a tick edge. Expect `led`=00 and `busy`=0 on the next edge, with no `done`.
- Handshake: hold `cmd_valid` with mode 2, reps 1 throughout, and change the mode while busy. The second command must be accepted only in the `done` cycle, must use the newly presented mode, and `cmd_ready` must stay low during RUN.
- Macro build: with `LED_ACT_LOW_EN` defined, repeat the SWEEP scenario. Expect FE,FD,..,7F,..,FE, with FF at reset and in IDLE.
